zvc_tile_scheduler: RTL and testbench

Sequencing controller for the 128-lane zero-value compressor pipeline. Accepts a tile command (number of LIFM/mapping-table lines), admits lines from the upstream line source into the compressor one per cycle, and tracks each line through the fixed-latency, non-stallable compressor. Admission is gated by credits for the downstream compressed-line buffer, so no result is ever dropped. Reports tile completion to the layer controller.

---
 rtl/zvc_tile_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_zvc_tile_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zvc_tile_scheduler.sv
// zvc_tile_scheduler: admits the lines of one tile into the fixed-latency
// zero-value compressor, gates admission on downstream buffer credits so no
// compressed line is ever dropped, tracks every line through the compressor
// latency and pulses done once the last line has left it.
module zvc_tile_scheduler #(
  parameter int PIPE_LAT  = 2,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] line_count,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 issue,
  output logic                 res_valid,
  output logic [CNT_WIDTH-1:0] res_idx,
  input  logic                 buf_pop,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CR_W = $clog2(OUT_DEPTH + 1);
  localparam logic [CR_W-1:0] CR_FULL = CR_W'(OUT_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CNT_WIDTH-1:0]  line_cnt_r;
  logic [CNT_WIDTH-1:0]  issued_cnt_r;
  logic [CNT_WIDTH-1:0]  retired_cnt_r;
  logic [CR_W-1:0]       credits_r;
  logic                  err_r;
  logic                  pipe_vld_r [PIPE_LAT];
  logic [CNT_WIDTH-1:0]  pipe_idx_r [PIPE_LAT];

  logic                  in_ready_s;
  logic                  issue_s;
  logic                  busy_s;
  logic                  done_s;
  logic                  res_valid_s;
  logic                  all_issued_s;
  logic                  retire_last_s;
  logic                  tile_load_s;

  // The compressor output stage belongs to an issued line when its valid is set.
  assign res_valid_s  = pipe_vld_r[PIPE_LAT-1];
  assign all_issued_s = (issued_cnt_r == line_cnt_r);
  // The line retiring this cycle is the last one of the tile; looking at it a
  // cycle early lets done follow the last result directly.
  assign retire_last_s = res_valid_s &&
                         (({1'b0, retired_cnt_r} + {{CNT_WIDTH{1'b0}}, 1'b1}) ==
                          {1'b0, line_cnt_r});
  assign tile_load_s  = (state_r == ST_IDLE) && start;
  assign issue_s      = in_valid && in_ready_s;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode of the tile sequencing.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (line_count == {CNT_WIDTH{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (all_issued_s) begin
          if (retire_last_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (retire_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State-decoded outputs; admission needs a free credit and an unissued line.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_RUN: begin
        in_ready_s = (credits_r != {CR_W{1'b0}}) && (issued_cnt_r < line_cnt_r);
        busy_s     = 1'b1;
      end
      ST_DRAIN: begin
        busy_s = 1'b1;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
      end
    endcase
  end

  // Tile line count and issue/retire counters, restarted by each accepted command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt_r    <= {CNT_WIDTH{1'b0}};
      issued_cnt_r  <= {CNT_WIDTH{1'b0}};
      retired_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (tile_load_s) begin
      line_cnt_r    <= line_count;
      issued_cnt_r  <= {CNT_WIDTH{1'b0}};
      retired_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (issue_s) begin
        issued_cnt_r <= issued_cnt_r + CNT_WIDTH'(1);
      end
      if (res_valid_s) begin
        retired_cnt_r <= retired_cnt_r + CNT_WIDTH'(1);
      end
    end
  end

  // Downstream buffer credits (kept across tiles) and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits_r <= CR_FULL;
      err_r     <= 1'b0;
    end else begin
      if (issue_s && !buf_pop) begin
        credits_r <= credits_r - CR_W'(1);
      end else if (buf_pop && !issue_s && (credits_r != CR_FULL)) begin
        credits_r <= credits_r + CR_W'(1);
      end
      if (buf_pop && (credits_r == CR_FULL)) begin
        err_r <= 1'b1;
      end
    end
  end

  // Latency shadow of the compressor: one {valid, index} slot per stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_vld_r[i] <= 1'b0;
        pipe_idx_r[i] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      pipe_vld_r[0] <= issue_s;
      pipe_idx_r[0] <= issued_cnt_r;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_idx_r[i] <= pipe_idx_r[i-1];
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign issue     = issue_s;
  assign res_valid = res_valid_s;
  assign res_idx   = pipe_idx_r[PIPE_LAT-1];
  assign busy      = busy_s;
  assign done      = done_s;
  assign err       = err_r;

endmodule

// File: tb/tb_zvc_tile_scheduler.sv
// Bench for zvc_tile_scheduler: a tile-level reference model (credit count,
// issued/retired line totals and a queue of in-flight results with their due
// cycle) is compared against the DUT on every falling edge, with directed
// scenarios and randomized tiles, plus literal expectations per scenario.
module tb_zvc_tile_scheduler;

  localparam int PL = 2;
  localparam int D  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] line_count = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          issue;
  logic          res_valid;
  logic [CW-1:0] res_idx;
  logic          buf_pop = 1'b0;
  logic          busy;
  logic          done;
  logic          err;

  zvc_tile_scheduler #(.PIPE_LAT(PL), .OUT_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .line_count(line_count),
    .in_valid(in_valid), .in_ready(in_ready), .issue(issue),
    .res_valid(res_valid), .res_idx(res_idx), .buf_pop(buf_pop),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { int due; int idx; } inflight_t;
  inflight_t q[$];
  int  cyc = 0;
  bit  m_active = 0;
  bit  m_done_p = 0;
  int  m_lc = 0;
  int  m_issued = 0;
  int  m_retired = 0;
  int  m_credits = D;
  bit  m_err = 0;

  // Observed DUT activity, used by the literal scenario expectations
  int obs_issue = 0, obs_res = 0, obs_done = 0;
  int obs_last_idx = -1, obs_last_res_cyc = -1, obs_last_done_cyc = -1;

  // Compare process: check outputs against the model, then advance the model
  always @(negedge clk) begin
    bit e_ready, e_issue, e_rv;
    int e_idx;
    if (!reset_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_issue", issue, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_idx", res_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      q.delete();
      m_active = 0; m_done_p = 0; m_lc = 0; m_issued = 0; m_retired = 0;
      m_credits = D; m_err = 0;
    end else begin
      e_ready = m_active && (m_credits > 0) && (m_issued < m_lc);
      e_issue = e_ready && in_valid;
      e_rv    = (q.size() > 0) && (q[0].due == cyc);
      e_idx   = e_rv ? q[0].idx : 0;
      chk("in_ready", in_ready, e_ready);
      chk("issue", issue, e_issue);
      chk("res_valid", res_valid, e_rv);
      if (e_rv && res_valid) chk("res_idx", res_idx, e_idx);
      chk("busy", busy, m_active);
      chk("done", done, m_done_p);
      chk("err", err, m_err);

      if (issue) obs_issue++;
      if (res_valid) begin
        obs_res++; obs_last_idx = res_idx; obs_last_res_cyc = cyc;
      end
      if (done) begin
        obs_done++; obs_last_done_cyc = cyc;
      end

      // credits and overflow flag
      if (buf_pop && m_credits == D) m_err = 1;
      if (e_issue && !buf_pop) m_credits--;
      else if (buf_pop && !e_issue && m_credits < D) m_credits++;

      // tile progress
      if (m_done_p) begin
        m_done_p = 0;
      end else if (!m_active) begin
        if (start) begin
          if (line_count == 0) m_done_p = 1;
          else begin
            m_active = 1; m_lc = line_count; m_issued = 0; m_retired = 0;
          end
        end
      end else begin
        if (e_issue) begin
          q.push_back('{due: cyc + PL, idx: m_issued});
          m_issued++;
        end
        if (e_rv) begin
          void'(q.pop_front());
          m_retired++;
          if (m_retired == m_lc) begin
            m_active = 0; m_done_p = 1;
          end
        end
      end
    end
    cyc++;
  end

  // Stimulus policies: vpol 0=always valid 1=toggle 2=random;
  // ppol 0=pop while buffer non-empty 1=never 2=random non-empty 3=manual
  int vpol = 0, ppol = 1;
  bit tog = 1'b1;
  bit rstart = 0;

  task automatic tick();
    @(posedge clk); #1;
    case (vpol)
      0: in_valid = 1'b1;
      1: begin in_valid = tog; tog = ~tog; end
      2: in_valid = 1'($urandom % 2);
      default: in_valid = 1'b0;
    endcase
    case (ppol)
      0: buf_pop = (D - m_credits) > 0;
      1: buf_pop = 1'b0;
      2: buf_pop = ((D - m_credits) > 0) && ($urandom % 2 == 0);
      default: ;
    endcase
    if (rstart) begin
      start = m_active ? ($urandom % 8 == 0) : 1'b0;
      line_count = CW'($urandom % 13);
    end
  endtask

  int c0;
  task automatic do_start(input int lc);
    start = 1'b1;
    line_count = CW'(lc);
    c0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_active || m_done_p) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", int'(m_active || m_done_p), 0);
  endtask

  task automatic pop_once();
    buf_pop = 1'b1;
    tick();
    buf_pop = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bi, br, bd;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Basic tile: 8 lines, full upstream rate, consumer keeps up
    vpol = 0; ppol = 0;
    bi = obs_issue; bd = obs_done;
    do_start(8);
    wait_idle(100);
    chk("basic_issues", obs_issue - bi, 8);
    chk("basic_done_count", obs_done - bd, 1);
    chk("basic_last_idx", obs_last_idx, 7);
    chk("basic_last_res_cycle", obs_last_res_cyc - c0, 8 + PL);
    chk("basic_done_cycle", obs_last_done_cyc - c0, 9 + PL);

    // Backpressure: no pops, 10 lines
    ppol = 1;
    repeat (3) tick();
    bi = obs_issue; bd = obs_done;
    do_start(10);
    repeat (20) tick();
    chk("bp_issues_stalled", obs_issue - bi, 4);
    chk("bp_busy_stalled", busy, 1);
    ppol = 3;
    for (int k = 0; k < 6; k++) pop_once();
    wait_idle(100);
    chk("bp_issues_total", obs_issue - bi, 10);
    chk("bp_done_count", obs_done - bd, 1);
    chk("bp_last_idx", obs_last_idx, 9);
    // no credits left: a new one-line tile must not issue until a pop
    bi = obs_issue;
    do_start(1);
    repeat (5) tick();
    chk("bp_zero_credits", obs_issue - bi, 0);
    for (int k = 0; k < 4; k++) pop_once();
    wait_idle(50);
    chk("bp_after_pops", obs_issue - bi, 1);
    ppol = 0;
    repeat (4) tick();

    // Upstream bubbles
    vpol = 1;
    bi = obs_issue; br = obs_res;
    do_start(5);
    wait_idle(100);
    chk("bubble_issues", obs_issue - bi, 5);
    chk("bubble_retired", obs_res - br, 5);
    chk("bubble_last_idx", obs_last_idx, 4);

    // Zero-line command
    vpol = 0;
    bi = obs_issue; bd = obs_done;
    do_start(0);
    wait_idle(10);
    chk("zero_done_cycle", obs_last_done_cyc - c0, 1);
    chk("zero_issues", obs_issue - bi, 0);
    chk("zero_done_count", obs_done - bd, 1);

    // Start during RUN is ignored
    bi = obs_issue;
    do_start(6);
    tick();
    start = 1'b1; line_count = CW'(3);
    tick();
    start = 1'b0;
    wait_idle(100);
    chk("ignored_start_issues", obs_issue - bi, 6);
    chk("ignored_start_last_idx", obs_last_idx, 5);

    // Credit overflow: pop with a full credit count
    repeat (4) tick();
    ppol = 3;
    buf_pop = 1'b1;
    tick();
    buf_pop = 1'b0;
    repeat (2) tick();
    chk("err_set", err, 1);
    repeat (5) tick();
    chk("err_sticky", err, 1);
    ppol = 1;
    bi = obs_issue;
    do_start(6);
    repeat (12) tick();
    chk("overflow_credits_held", obs_issue - bi, 4);
    ppol = 0;
    wait_idle(100);

    // Reset with lines in flight
    repeat (3) tick();
    do_start(2);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("rst_now_res_valid", res_valid, 0);
    chk("rst_now_busy", busy, 0);
    chk("rst_now_done", done, 0);
    chk("rst_now_err", err, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    bi = obs_issue; br = obs_res;
    do_start(3);
    wait_idle(50);
    chk("post_rst_issues", obs_issue - bi, 3);
    chk("post_rst_retired", obs_res - br, 3);
    chk("post_rst_last_idx", obs_last_idx, 2);

    // Randomized tiles
    vpol = 2; ppol = 2; rstart = 1;
    for (int t = 0; t < 40; t++) begin
      do_start(int'($urandom % 13));
      wait_idle(400);
      repeat (int'($urandom % 3)) tick();
    end
    rstart = 0;
    start = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
